// File: rtl/chain_sb_pkg.sv
// Shared types for the FIFO-chain scoreboard: tracker state and sticky error codes.
package chain_sb_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, DONE} sb_state_e;
  typedef enum logic [2:0] {
    E_NONE = 3'd0,
    E_DATA = 3'd1,
    E_FLAG = 3'd2,
    E_OVF  = 3'd3,
    E_UDF  = 3'd4
  } sb_err_e;
endpackage

// File: rtl/chain_sb_if.sv
// Observation bus between a FIFO chain (or its stimulus) and the chain scoreboard.
interface chain_sb_if #(
  parameter int WIDTH   = 8,
  parameter int NSTAGES = 2
);
  localparam int SW = $clog2(NSTAGES) + 1;

  logic               start;
  logic               push;
  logic [WIDTH-1:0]   data_in;
  logic [NSTAGES-1:0] pop;
  logic [WIDTH-1:0]   data_out;
  logic [NSTAGES-1:0] empty_ref;
  logic [NSTAGES-1:0] full_ref;
  logic               tracking;
  logic               done;
  logic [SW-1:0]      stage_idx;
  logic [2:0]         err;
  logic               prop_signal;

  modport master (
    output start, push, data_in, pop, data_out, empty_ref, full_ref,
    input  tracking, done, stage_idx, err, prop_signal
  );
  modport slave (
    input  start, push, data_in, pop, data_out, empty_ref, full_ref,
    output tracking, done, stage_idx, err, prop_signal
  );
endinterface

// File: rtl/chain_sb_occ.sv
// Shadow occupancy counter for one FIFO stage with overflow/underflow/flag checks.
module chain_sb_occ #(
  parameter int DEPTH       = 4,
  parameter int CHECK_FLAGS = 1,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic          pop,
  input  logic          empty_ref,
  input  logic          full_ref,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          udf,
  output logic          flag_err
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_full, is_empty;

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    ovf      = in_vld && !pop && is_full;
    udf      = pop && is_empty;
    // Counter saturates at both ends; a simultaneous in/out leaves it unchanged.
    if (in_vld && !pop && !is_full)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !in_vld && !is_empty)
      cnt_d = cnt_q - CW'(1);
    flag_err = (CHECK_FLAGS != 0) &&
               ((empty_ref != is_empty) || (full_ref != is_full));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/chain_scoreboard.sv
// End-to-end scoreboard for NSTAGES chained FIFOs: tracks one magic packet to
// egress, checks its data, and checks each stage's flags against shadow counts.
module chain_scoreboard
  import chain_sb_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int NSTAGES     = 2,
  parameter int CHECK_FLAGS = 1
) (
  input logic      clk,
  input logic      rst_n,
  chain_sb_if.slave sb
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NSTAGES) + 1;

  logic [NSTAGES-1:0][CW-1:0] cnt;
  logic [NSTAGES-1:0]         in_vld, ovf, udf, flag_err;

  for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
    if (i == 0) begin : g_in
      assign in_vld[i] = sb.push;
    end else begin : g_in
      assign in_vld[i] = sb.pop[i-1];
    end
    chain_sb_occ #(.DEPTH(DEPTH), .CHECK_FLAGS(CHECK_FLAGS), .CW(CW)) u_occ (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld[i]), .pop(sb.pop[i]),
      .empty_ref(sb.empty_ref[i]), .full_ref(sb.full_ref[i]),
      .cnt(cnt[i]), .ovf(ovf[i]), .udf(udf[i]), .flag_err(flag_err[i])
    );
  end

  sb_state_e        state_q, state_d;
  sb_err_e          err_q, err_d;
  logic [WIDTH-1:0] magic_q, magic_d;
  logic [CW-1:0]    ahead_q, ahead_d, ahead0, nxt_ahead;
  logic [SW-1:0]    stage_q, stage_d;
  logic             cur_pop, data_err;

  // Entries ahead of a packet entering a stage: that stage's pre-update count
  // less any entry leaving it in the same cycle.
  always_comb begin
    ahead0    = (sb.pop[0] && cnt[0] != '0) ? cnt[0] - CW'(1) : cnt[0];
    cur_pop   = 1'b0;
    nxt_ahead = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (SW'(i) == stage_q) cur_pop = sb.pop[i];
      if (i > 0 && SW'(i) == stage_q + SW'(1))
        nxt_ahead = (sb.pop[i] && cnt[i] != '0) ? cnt[i] - CW'(1) : cnt[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    magic_d  = magic_q;
    ahead_d  = ahead_q;
    stage_d  = stage_q;
    data_err = 1'b0;
    case (state_q)
      IDLE: if (sb.start && sb.push) begin
        magic_d = sb.data_in;
        ahead_d = ahead0;
        stage_d = '0;
        state_d = TRACK;
      end
      TRACK: if (cur_pop) begin
        if (ahead_q != '0) begin
          ahead_d = ahead_q - CW'(1);
        end else if (stage_q != SW'(NSTAGES - 1)) begin
          stage_d = stage_q + SW'(1);
          ahead_d = nxt_ahead;
        end else begin
          data_err = (sb.data_out != magic_q);
          stage_d  = '0;
          state_d  = DONE;
        end
      end
      default: ;
    endcase
  end

  // First error wins; simultaneous errors resolve in code order.
  always_comb begin
    err_d = err_q;
    if (err_q == E_NONE) begin
      if (data_err)        err_d = E_DATA;
      else if (|flag_err)  err_d = E_FLAG;
      else if (|ovf)       err_d = E_OVF;
      else if (|udf)       err_d = E_UDF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= E_NONE;
      magic_q <= '0;
      ahead_q <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      magic_q <= magic_d;
      ahead_q <= ahead_d;
      stage_q <= stage_d;
    end
  end

  assign sb.tracking    = (state_q == TRACK);
  assign sb.done        = (state_q == DONE);
  assign sb.stage_idx   = stage_q;
  assign sb.err         = err_q;
  assign sb.prop_signal = (err_q == E_NONE);
endmodule
